// File: rtl/acq_seq_pkg.sv
// Shared types and legacy timing defaults for the programmable acquisition sequencer.
package acq_seq_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Timing of the fixed-count sequencer this block replaces, in clk cycles.
   localparam logic [31:0] DEF_PERIOD = 32'd1000000000;
   localparam logic [31:0] DEF_T_AGC  = 32'd48000000;
   localparam logic [31:0] DEF_T_LD   = 32'd500000000;
   localparam logic [31:0] DEF_T_EN   = 32'd500000100;

endpackage

// File: rtl/acq_seq_chan.sv
// Per-channel output stage: registers the ldctrl pulse and holds the enable level.
module acq_seq_chan (
   input  logic clk,
   input  logic arstn,
   input  logic clr,
   input  logic ld_stb,
   input  logic en_stb,
   input  logic dis_stb,
   input  logic end_stb,
   input  logic mask,
   output logic ldctrl,
   output logic enable
);

   // Clearing (abort, disable count, frame end) wins over a set at the same count.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         ldctrl <= 1'b0;
         enable <= 1'b0;
      end else begin
         ldctrl <= ld_stb & mask;
         if (clr || dis_stb || end_stb) begin
            enable <= 1'b0;
         end else if (en_stb && mask) begin
            enable <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/acq_sequencer.sv
// Programmable acquisition sequencer: frame counter, event compares and run/idle FSM.
// Optional completed-frame counter is built only when ACQ_SEQ_FRAMECNT_EN is defined.
module acq_sequencer
   import acq_seq_pkg::*;
#(
   parameter int NCH  = 2,
   parameter int CNTW = 32
) (
   input  logic            clk,
   input  logic            arstn,
   input  logic            start,
   input  logic            abort,
   input  logic            periodic,
   input  logic [NCH-1:0]  ch_mask,
   input  logic [CNTW-1:0] t_period,
   input  logic [CNTW-1:0] t_agc,
   input  logic [CNTW-1:0] t_ld,
   input  logic [CNTW-1:0] t_en,
   input  logic [CNTW-1:0] t_dis,
   output logic            agc_load,
   output logic [NCH-1:0]  ldctrl,
   output logic [NCH-1:0]  enable,
   output logic            busy,
   output logic            cfg_err,
   output logic [15:0]     frame_cnt
);

   localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

   state_t          state_q;
   state_t          state_d;
   logic            accept;
   logic            refuse;

   logic [CNTW-1:0] cnt_q;
   logic            per_q;
   logic [NCH-1:0]  mask_q;
   logic [CNTW-1:0] t_period_q;
   logic [CNTW-1:0] t_agc_q;
   logic [CNTW-1:0] t_ld_q;
   logic [CNTW-1:0] t_en_q;
   logic [CNTW-1:0] t_dis_q;

   logic            in_run;
   logic            run_act;
   logic            end_hit;
   logic            ld_stb;
   logic            en_stb;
   logic            dis_stb;
   logic            end_stb;
   logic            clr;

   // Strobes fire only while running and not being aborted, so an abort cycle emits nothing.
   assign in_run  = (state_q == ST_RUN);
   assign run_act = in_run & ~abort;
   assign end_hit = (cnt_q == t_period_q);
   assign ld_stb  = run_act & (cnt_q == t_ld_q);
   assign en_stb  = run_act & (cnt_q == t_en_q);
   assign dis_stb = run_act & (cnt_q == t_dis_q);
   assign end_stb = run_act & end_hit;
   assign clr     = in_run & abort;

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Abort outranks both start and end of frame; a zero period refuses the start.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      refuse  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               if (t_period != '0) begin
                  accept  = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  refuse = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (end_hit && !per_q) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Configuration is frozen at an accepted start; later input changes wait for the next one.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         per_q      <= 1'b0;
         mask_q     <= '0;
         t_period_q <= '0;
         t_agc_q    <= '0;
         t_ld_q     <= '0;
         t_en_q     <= '0;
         t_dis_q    <= '0;
      end else if (accept) begin
         per_q      <= periodic;
         mask_q     <= ch_mask;
         t_period_q <= t_period;
         t_agc_q    <= t_agc;
         t_ld_q     <= t_ld;
         t_en_q     <= t_en;
         t_dis_q    <= t_dis;
      end
   end

   // The counter restarts at every frame end, so it never runs past t_period.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         cnt_q <= '0;
      end else if (run_act && !end_hit) begin
         cnt_q <= cnt_q + CNT_ONE;
      end else begin
         cnt_q <= '0;
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         agc_load <= 1'b0;
         busy     <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         agc_load <= run_act & (cnt_q == t_agc_q);
         busy     <= (state_d == ST_RUN);
         if (accept) begin
            cfg_err <= 1'b0;
         end else if (refuse) begin
            cfg_err <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      acq_seq_chan u_chan (
         .clk     (clk),
         .arstn   (arstn),
         .clr     (clr),
         .ld_stb  (ld_stb),
         .en_stb  (en_stb),
         .dis_stb (dis_stb),
         .end_stb (end_stb),
         .mask    (mask_q[i]),
         .ldctrl  (ldctrl[i]),
         .enable  (enable[i])
      );
   end

`ifdef ACQ_SEQ_FRAMECNT_EN
   logic [15:0] frame_q;

   // Counts frames that reach their end count; an aborted frame is not counted.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         frame_q <= 16'd0;
      end else if (accept) begin
         frame_q <= 16'd0;
      end else if (end_stb && (frame_q != 16'hFFFF)) begin
         frame_q <= frame_q + 16'd1;
      end
   end

   assign frame_cnt = frame_q;
`else
   assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: table-driven frames plus abort/reset/config-error sequences.
module tb_acq_sequencer;

   logic        clk = 1'b0;
   logic        arstn = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        periodic = 1'b0;
   logic [1:0]  ch_mask = 2'b00;
   logic [31:0] t_period = '0;
   logic [31:0] t_agc = '0;
   logic [31:0] t_ld = '0;
   logic [31:0] t_en = '0;
   logic [31:0] t_dis = '0;
   logic        agc_load;
   logic [1:0]  ldctrl;
   logic [1:0]  enable;
   logic        busy;
   logic        cfg_err;
   logic [15:0] frame_cnt;

   acq_sequencer #(.NCH(2), .CNTW(32)) dut (
      .clk       (clk),
      .arstn     (arstn),
      .start     (start),
      .abort     (abort),
      .periodic  (periodic),
      .ch_mask   (ch_mask),
      .t_period  (t_period),
      .t_agc     (t_agc),
      .t_ld      (t_ld),
      .t_en      (t_en),
      .t_dis     (t_dis),
      .agc_load  (agc_load),
      .ldctrl    (ldctrl),
      .enable    (enable),
      .busy      (busy),
      .cfg_err   (cfg_err),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        agc;
      logic [1:0]  ld;
      logic [1:0]  en;
      logic        busy;
      logic        err;
      logic [15:0] fc;
   } exp_t;

   // Edge numbers count clock edges after the accepting edge; 0 means the event never shows.
   typedef struct {
      int         period;
      int         agc;
      int         ld;
      int         en;
      int         dis;
      logic [1:0] mask;
      logic       periodic;
      int         agc_edge;
      int         ld_edge;
      int         en_rise;
      int         en_fall;
      int         ncyc;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[5];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [15:0] fcv(input int f);
`ifdef ACQ_SEQ_FRAMECNT_EN
      return 16'(f);
`else
      return (f < 0) ? 16'd1 : 16'd0;
`endif
   endfunction

   function automatic exp_t idle_exp(input int f, input logic err);
      exp_t e;
      e     = '0;
      e.fc  = fcv(f);
      e.err = err;
      return e;
   endfunction

   function automatic exp_t busy_exp();
      exp_t e;
      e      = '0;
      e.busy = 1'b1;
      return e;
   endfunction

   function automatic exp_t model(input vec_t v, input int k);
      exp_t e;
      int   len;
      int   kk;
      e   = '0;
      len = v.period + 1;
      if (!v.periodic && k > len) begin
         e.fc = fcv(1);
         return e;
      end
      kk     = ((k - 1) % len) + 1;
      e.agc  = (kk == v.agc_edge);
      e.ld   = (kk == v.ld_edge) ? v.mask : 2'b00;
      e.en   = (kk >= v.en_rise && kk < v.en_fall) ? v.mask : 2'b00;
      e.busy = v.periodic || (k < len);
      e.fc   = fcv(k / len);
      return e;
   endfunction

   task automatic checkOutput(input string name);
      exp_t e;
      exp_t act;
      e   = sb.pop_front();
      act = {agc_load, ldctrl, enable, busy, cfg_err, frame_cnt};
      checks++;
      if (act !== e) begin
         errors++;
         $display("[TB] FAIL %s: got agc=%0b ld=%b en=%b busy=%0b err=%0b fc=%0d, expected agc=%0b ld=%b en=%b busy=%0b err=%0b fc=%0d",
                  name, act.agc, act.ld, act.en, act.busy, act.err, act.fc,
                  e.agc, e.ld, e.en, e.busy, e.err, e.fc);
      end
   endtask

   task automatic cycle(input exp_t e, input string name);
      sb.push_back(e);
      @(posedge clk);
      #1;
      checkOutput(name);
   endtask

   task automatic applyStimulus(input vec_t v);
      periodic = v.periodic;
      ch_mask  = v.mask;
      t_period = v.period;
      t_agc    = v.agc;
      t_ld     = v.ld;
      t_en     = v.en;
      t_dis    = v.dis;
   endtask

   task automatic startFrame(input string name);
      start = 1'b1;
      cycle(busy_exp(), name);
      start = 1'b0;
   endtask

   task automatic runVector(input int idx);
      vec_t v;
      int   len;
      v   = vecs[idx];
      len = v.period + 1;
      applyStimulus(v);
      startFrame($sformatf("vec%0d start", idx));
      for (int k = 1; k <= v.ncyc; k++) begin
         cycle(model(v, k), $sformatf("vec%0d k%0d", idx, k));
      end
      if (v.periodic) begin
         abort = 1'b1;
         cycle(idle_exp(v.ncyc / len, 1'b0), $sformatf("vec%0d abort", idx));
         abort = 1'b0;
         cycle(idle_exp(v.ncyc / len, 1'b0), $sformatf("vec%0d idle", idx));
      end
   endtask

   initial begin
      // period agc ld en dis mask per | agc_edge ld_edge en_rise en_fall ncyc
      vecs[0] = '{100,   5, 10, 20, 60, 2'b11, 1'b0,   6,  11, 21,  61, 104};
      vecs[1] = '{100,   5, 10, 20, 60, 2'b10, 1'b0,   6,  11, 21,  61, 104};
      vecs[2] = '{100, 100, 10, 40, 40, 2'b11, 1'b0, 101,  11,  0,   0, 104};
      vecs[3] = '{ 30,  40, 30,  5, 50, 2'b01, 1'b0,   0,  31,  6,  31,  34};
      vecs[4] = '{ 50,   3,  7, 10, 60, 2'b11, 1'b1,   4,   8, 11,  51, 160};

      #12;
      sb.push_back(idle_exp(0, 1'b0));
      checkOutput("reset");
      @(negedge clk);
      arstn = 1'b1;
      cycle(idle_exp(0, 1'b0), "post-reset idle");

      for (int i = 0; i < 5; i++) begin
         runVector(i);
      end

      // Abort at count 30 with enables high; a start and new inputs mid-frame are ignored.
      applyStimulus(vecs[0]);
      startFrame("abort start");
      for (int k = 1; k <= 30; k++) begin
         if (k == 10) begin
            start    = 1'b1;
            t_en     = 32'd5;
            ch_mask  = 2'b00;
            t_period = 32'd0;
         end else if (k == 11) begin
            start = 1'b0;
            applyStimulus(vecs[0]);
         end
         cycle(model(vecs[0], k), $sformatf("abort run k%0d", k));
      end
      abort = 1'b1;
      cycle(idle_exp(0, 1'b0), "abort edge");
      abort = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle(idle_exp(0, 1'b0), "after abort");
      end
      startFrame("restart");
      for (int k = 1; k <= 25; k++) begin
         cycle(model(vecs[0], k), $sformatf("restart k%0d", k));
      end
      abort = 1'b1;
      cycle(idle_exp(0, 1'b0), "restart abort");
      abort = 1'b0;

      // Start together with abort in idle, then a refused zero-period start.
      start = 1'b1;
      abort = 1'b1;
      cycle(idle_exp(0, 1'b0), "start+abort idle");
      start = 1'b0;
      abort = 1'b0;
      t_period = 32'd0;
      start = 1'b1;
      cycle(idle_exp(0, 1'b1), "cfg_err set");
      start = 1'b0;
      cycle(idle_exp(0, 1'b1), "cfg_err hold");
      applyStimulus(vecs[0]);
      startFrame("cfg_err clear");
      abort = 1'b1;
      cycle(idle_exp(0, 1'b0), "abort at count 0");
      abort = 1'b0;

      // Asynchronous reset in the middle of a frame.
      applyStimulus(vecs[0]);
      startFrame("reset-run start");
      for (int k = 1; k <= 25; k++) begin
         cycle(model(vecs[0], k), $sformatf("reset-run k%0d", k));
      end
      #2;
      arstn = 1'b0;
      #1;
      sb.push_back(idle_exp(0, 1'b0));
      checkOutput("async reset");
      @(posedge clk);
      @(negedge clk);
      arstn = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle(idle_exp(0, 1'b0), "after reset release");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
